// File: rtl/pipelined_control_unit_pkg.sv
// Shared constants and types for the pipelined control unit: instruction modes,
// data-processing opcodes, ALU commands, FSM states and the decoded control word.
package pipelined_control_unit_pkg;

    localparam int CMD_W = 4;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_LS  = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;
    localparam logic [1:0] MODE_BLK = 2'b11;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [CMD_W-1:0] ALU_NOP = 4'b0000;
    localparam logic [CMD_W-1:0] ALU_MOV = 4'b0001;
    localparam logic [CMD_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [CMD_W-1:0] ALU_ADC = 4'b0011;
    localparam logic [CMD_W-1:0] ALU_SUB = 4'b0100;
    localparam logic [CMD_W-1:0] ALU_SBC = 4'b0101;
    localparam logic [CMD_W-1:0] ALU_AND = 4'b0110;
    localparam logic [CMD_W-1:0] ALU_ORR = 4'b0111;
    localparam logic [CMD_W-1:0] ALU_EOR = 4'b1000;
    localparam logic [CMD_W-1:0] ALU_MVN = 4'b1001;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } state_e;

    typedef struct packed {
        logic [CMD_W-1:0] alu_cmd;
        logic             mem_read;
        logic             mem_write;
        logic             wb_en;
        logic             branch;
        logic             status_en;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '0;

    function automatic ctrl_word_t dp_word(input logic [CMD_W-1:0] cmd,
                                           input logic wb,
                                           input logic st);
        ctrl_word_t w;
        w           = CTRL_NOP;
        w.alu_cmd   = cmd;
        w.wb_en     = wb;
        w.status_en = st;
        return w;
    endfunction

endpackage

// File: rtl/pipelined_control_unit_if.sv
// Decode-side handshake and ID/EX control bus of the pipelined control unit.
// master drives instructions and pipeline controls; slave is the control unit.
interface pipelined_control_unit_if #(
    parameter int NUM_REGS  = 16,
    parameter int ALU_CMD_W = 4,
    parameter int OFFSET_W  = 8
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           mode;
    logic [3:0]           op_code;
    logic                 s;
    logic [NUM_REGS-1:0]  reg_list;
    logic                 stall;
    logic                 flush;
    logic                 out_valid;
    logic [ALU_CMD_W-1:0] alu_cmd;
    logic                 mem_read;
    logic                 mem_write;
    logic                 wb_en;
    logic                 branch;
    logic                 status_en;
    logic [IDX_W-1:0]     xfer_reg;
    logic [OFFSET_W-1:0]  addr_offset;
    logic                 last_uop;

    modport master (
        output in_valid, mode, op_code, s, reg_list, stall, flush,
        input  in_ready, out_valid, alu_cmd, mem_read, mem_write, wb_en,
               branch, status_en, xfer_reg, addr_offset, last_uop
    );

    modport slave (
        input  in_valid, mode, op_code, s, reg_list, stall, flush,
        output in_ready, out_valid, alu_cmd, mem_read, mem_write, wb_en,
               branch, status_en, xfer_reg, addr_offset, last_uop
    );
endinterface

// File: rtl/pipelined_control_unit_ctrl_decode.sv
// Purely combinational mode/op_code/s decoder producing the control word.
// Block-transfer mode decodes as a NOP here; the sequencer overrides it.
module pipelined_control_unit_ctrl_decode
    import pipelined_control_unit_pkg::*;
(
    input  logic [1:0] i_mode,
    input  logic [3:0] i_op_code,
    input  logic       i_s,
    output ctrl_word_t o_ctrl
);

    // Instruction class and opcode to control word
    always_comb begin
        o_ctrl = CTRL_NOP;
        case (i_mode)
            MODE_DP: begin
                case (i_op_code)
                    OP_MOV:  o_ctrl = dp_word(ALU_MOV, 1'b1, i_s);
                    OP_MVN:  o_ctrl = dp_word(ALU_MVN, 1'b1, i_s);
                    OP_ADD:  o_ctrl = dp_word(ALU_ADD, 1'b1, i_s);
                    OP_ADC:  o_ctrl = dp_word(ALU_ADC, 1'b1, i_s);
                    OP_SUB:  o_ctrl = dp_word(ALU_SUB, 1'b1, i_s);
                    OP_SBC:  o_ctrl = dp_word(ALU_SBC, 1'b1, i_s);
                    OP_AND:  o_ctrl = dp_word(ALU_AND, 1'b1, i_s);
                    OP_ORR:  o_ctrl = dp_word(ALU_ORR, 1'b1, i_s);
                    OP_EOR:  o_ctrl = dp_word(ALU_EOR, 1'b1, i_s);
                    OP_CMP:  o_ctrl = dp_word(ALU_SUB, 1'b0, 1'b1);
                    OP_TST:  o_ctrl = dp_word(ALU_AND, 1'b0, 1'b1);
                    default: o_ctrl = CTRL_NOP;
                endcase
            end
            MODE_LS: begin
                o_ctrl.alu_cmd   = ALU_ADD;
                o_ctrl.mem_read  = i_s;
                o_ctrl.wb_en     = i_s;
                o_ctrl.mem_write = ~i_s;
            end
            MODE_BR: begin
                o_ctrl.branch = 1'b1;
            end
            default: begin
                o_ctrl = CTRL_NOP;
            end
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Registered ID/EX control unit with valid/ready handshake, stall and flush.
// Define BLOCK_XFER_EN to build the LDM/STM micro-sequencer (mode 2'b11).
module pipelined_control_unit
    import pipelined_control_unit_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int ALU_CMD_W  = 4,
    parameter int OFFSET_W   = 8,
    parameter int WORD_BYTES = 4
) (
    input  logic clk,
    input  logic rst_n,
    pipelined_control_unit_if.slave bus
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    ctrl_word_t          w_dec_ctrl;
    ctrl_word_t          w_ctrl_nx;
    ctrl_word_t          r_ctrl;
    logic                w_valid_nx;
    logic                r_out_valid;
    logic                w_last_nx;
    logic                r_last_uop;
    logic [IDX_W-1:0]    w_xfer_nx;
    logic [IDX_W-1:0]    r_xfer_reg;
    logic [OFFSET_W-1:0] w_off_nx;
    logic [OFFSET_W-1:0] r_addr_offset;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_issue;
    logic                w_blk_nop;
    logic                w_uop_load;
    logic [NUM_REGS-1:0] w_seq_src;
    logic [NUM_REGS-1:0] w_remaining;
    logic [OFFSET_W-1:0] w_uop_off;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_REGS-1:0] list);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            idx = list[i] ? IDX_W'(i) : idx;
        end
        return idx;
    endfunction

    pipelined_control_unit_ctrl_decode u_ctrl_decode (
        .i_mode    (bus.mode),
        .i_op_code (bus.op_code),
        .i_s       (bus.s),
        .o_ctrl    (w_dec_ctrl)
    );

`ifdef BLOCK_XFER_EN
    localparam logic [NUM_REGS-1:0] ONE_LIST = NUM_REGS'(1);
    localparam logic [OFFSET_W-1:0] OFF_STEP = OFFSET_W'(WORD_BYTES);

    state_e              r_state;
    state_e              w_state_nx;
    logic [NUM_REGS-1:0] r_pending;
    logic [OFFSET_W-1:0] r_next_off;
    logic                r_is_load;
    logic                w_is_blk;

    assign w_is_blk = (bus.mode == MODE_BLK);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next state: a multi-register list enters SEQ, the emptying micro-op leaves it
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_issue && (w_remaining != '0)) begin
                    w_state_nx = ST_SEQ;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_SEQ: begin
                if (bus.flush || (w_issue && (w_remaining == '0))) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_SEQ;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake and source of the next micro-op
    always_comb begin
        w_in_ready = 1'b0;
        w_seq_src  = bus.reg_list;
        w_uop_load = bus.s;
        w_uop_off  = '0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = ~bus.stall & ~bus.flush;
                w_seq_src  = bus.reg_list;
                w_uop_load = bus.s;
                w_uop_off  = '0;
            end
            ST_SEQ: begin
                w_in_ready = 1'b0;
                w_seq_src  = r_pending;
                w_uop_load = r_is_load;
                w_uop_off  = r_next_off;
            end
            default: begin
                w_in_ready = 1'b0;
                w_seq_src  = '0;
                w_uop_load = 1'b0;
                w_uop_off  = '0;
            end
        endcase
    end

    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_remaining = w_seq_src & (w_seq_src - ONE_LIST);
    assign w_issue     = (r_state == ST_SEQ) ? (~bus.stall & ~bus.flush)
                                             : (w_accept & w_is_blk & (bus.reg_list != '0));
    assign w_blk_nop   = w_accept & w_is_blk & (bus.reg_list == '0);

    // Pending list, next offset and transfer direction of the running sequence
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_next_off <= '0;
            r_is_load  <= 1'b0;
        end else if (bus.flush) begin
            r_pending  <= '0;
            r_next_off <= '0;
            r_is_load  <= 1'b0;
        end else if (w_issue) begin
            r_pending  <= w_remaining;
            r_next_off <= w_uop_off + OFF_STEP;
            r_is_load  <= w_uop_load;
        end else begin
            r_pending  <= r_pending;
            r_next_off <= r_next_off;
            r_is_load  <= r_is_load;
        end
    end
`else
    logic w_unused;

    assign w_in_ready  = ~bus.stall & ~bus.flush;
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_issue     = 1'b0;
    assign w_blk_nop   = 1'b0;
    assign w_uop_load  = 1'b0;
    assign w_seq_src   = '0;
    assign w_remaining = '0;
    assign w_uop_off   = '0;
    assign w_unused    = ^{bus.reg_list, WORD_BYTES[0]};
`endif

    // Next ID/EX contents: flush clears, stall holds, then micro-op, decode or bubble
    always_comb begin
        w_valid_nx = r_out_valid;
        w_ctrl_nx  = r_ctrl;
        w_xfer_nx  = r_xfer_reg;
        w_off_nx   = r_addr_offset;
        w_last_nx  = r_last_uop;
        if (bus.flush) begin
            w_valid_nx = 1'b0;
            w_ctrl_nx  = CTRL_NOP;
            w_xfer_nx  = '0;
            w_off_nx   = '0;
            w_last_nx  = 1'b0;
        end else if (bus.stall) begin
            w_valid_nx = r_out_valid;
            w_ctrl_nx  = r_ctrl;
            w_xfer_nx  = r_xfer_reg;
            w_off_nx   = r_addr_offset;
            w_last_nx  = r_last_uop;
        end else if (w_issue) begin
            w_valid_nx          = 1'b1;
            w_ctrl_nx           = CTRL_NOP;
            w_ctrl_nx.alu_cmd   = ALU_ADD;
            w_ctrl_nx.mem_read  = w_uop_load;
            w_ctrl_nx.wb_en     = w_uop_load;
            w_ctrl_nx.mem_write = ~w_uop_load;
            w_xfer_nx           = lowest_idx(w_seq_src);
            w_off_nx            = w_uop_off;
            w_last_nx           = (w_remaining == '0);
        end else if (w_accept && !w_blk_nop) begin
            w_valid_nx = 1'b1;
            w_ctrl_nx  = w_dec_ctrl;
            w_xfer_nx  = '0;
            w_off_nx   = '0;
            w_last_nx  = 1'b1;
        end else begin
            w_valid_nx = 1'b0;
            w_ctrl_nx  = CTRL_NOP;
            w_xfer_nx  = '0;
            w_off_nx   = '0;
            w_last_nx  = 1'b0;
        end
    end

    // ID/EX output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_ctrl        <= CTRL_NOP;
            r_xfer_reg    <= '0;
            r_addr_offset <= '0;
            r_last_uop    <= 1'b0;
        end else begin
            r_out_valid   <= w_valid_nx;
            r_ctrl        <= w_ctrl_nx;
            r_xfer_reg    <= w_xfer_nx;
            r_addr_offset <= w_off_nx;
            r_last_uop    <= w_last_nx;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.alu_cmd     = ALU_CMD_W'(r_ctrl.alu_cmd);
    assign bus.mem_read    = r_ctrl.mem_read;
    assign bus.mem_write   = r_ctrl.mem_write;
    assign bus.wb_en       = r_ctrl.wb_en;
    assign bus.branch      = r_ctrl.branch;
    assign bus.status_en   = r_ctrl.status_en;
    assign bus.xfer_reg    = r_xfer_reg;
    assign bus.addr_offset = r_addr_offset;
    assign bus.last_uop    = r_last_uop;

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Registered, parametrised successor of the ID-stage control decoder.
- Decodes mode/op_code/s into ALU command and memory/writeback/branch/status controls, and registers them into the ID/EX boundary.
- Adds a valid/ready handshake, stall and flush.
- Adds a block-transfer micro-sequencer (LDM/STM, mode 2'b11) that expands one instruction into one micro-op per register in a register list.

Parameters:
- NUM_REGS, 16, width of the register-list field; register index width is clog2(NUM_REGS).
- ALU_CMD_W, 4, width of the ALU command output.
- OFFSET_W, 8, width of the block-transfer address offset; must be at least clog2(NUM_REGS)+2.
- WORD_BYTES, 4, per-micro-op offset increment.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  decode inputs valid.
- in_ready  out  1  block accepts an instruction this cycle.
- mode  in  2  instruction class: 00 data-proc, 01 LDR/STR, 10 branch, 11 block transfer.
- op_code  in  4  data-processing opcode.
- s  in  1  S bit; in modes 01 and 11, 1 = load, 0 = store.
- reg_list  in  NUM_REGS  block-transfer register list; bit i selects register i.
- stall  in  1  hold the output register and the FSM.
- flush  in  1  kill the output and any pending sequence.
- out_valid  out  1  registered control word is valid.
- alu_cmd  out  ALU_CMD_W  ALU command.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- wb_en  out  1  writeback enable.
- branch  out  1  branch taken.
- status_en  out  1  status-register update enable.
- xfer_reg  out  clog2(NUM_REGS)  register index of the current block micro-op.
- addr_offset  out  OFFSET_W  byte offset of the current block micro-op.
- last_uop  out  1  final micro-op of the instruction; 1 for all single-op instructions.

Behaviour:
- Reset (rst_n=0 at a clk edge): every output is 0 except in_ready=1; FSM goes to IDLE; pending list is cleared.

Decode, data-processing (mode 00), as op_code -> alu_cmd, wb_en, status_en:
- MOV 1101 -> 0001, wb 1, status = s.
- MVN 1111 -> 1001, wb 1, status = s.
- ADD 0100 -> 0010, wb 1, status = s.
- ADC 0101 -> 0011, wb 1, status = s.
- SUB 0010 -> 0100, wb 1, status = s.
- SBC 0110 -> 0101, wb 1, status = s.
- AND 0000 -> 0110, wb 1, status = s.
- ORR 1100 -> 0111, wb 1, status = s.
- EOR 0001 -> 1000, wb 1, status = s.
- CMP 1010 -> 0100, wb 0, status 1.
- TST 1000 -> 0110, wb 0, status 1.
- Any other op_code -> all controls 0, out_valid=1 (NOP).

Decode, other modes:
- mode 01: alu_cmd 0010. s=1 gives mem_read=1, wb_en=1. s=0 gives mem_write=1. status_en=0.
- mode 10: branch=1; all other controls 0.

Timing and handshake:
- Accept occurs when in_valid & in_ready.
- Controls appear on the outputs one cycle after accept, with out_valid=1.
- With no accept and no active sequence, out_valid=0 next cycle.

FSM IDLE / SEQ:
- IDLE: in_ready = ~stall.
- Accepting mode 11 with a nonzero reg_list latches the list into a pending register and goes to SEQ.
- SEQ: in_ready=0. Each non-stalled cycle emits one micro-op:
  - xfer_reg = index of the lowest set pending bit; that bit is then cleared.
  - addr_offset = n*WORD_BYTES, where n is the micro-op ordinal starting at 0.
  - alu_cmd 0010; load gives mem_read and wb_en; store gives mem_write.
  - last_uop=1 on the micro-op that empties the list; the FSM then returns to IDLE.
- The first micro-op is emitted on the cycle after accept.
- An empty reg_list is consumed as a NOP: out_valid=0 and no state change.

Stall and flush:
- stall=1: outputs hold their values, FSM and pending list frozen, in_ready=0.
- flush=1: next cycle out_valid=0 and all controls 0, FSM to IDLE, pending list cleared, any input that cycle is not accepted. flush has priority over stall.
- rst_n has priority over flush.

Optional Feature:
- Macro: BLOCK_XFER_EN.
- Defined: the mode 11 micro-sequencer, xfer_reg and addr_offset behave as above.
- Undefined: mode 11 decodes as a NOP, the FSM is absent, in_ready = ~stall, xfer_reg=0, addr_offset=0, last_uop = out_valid.

Decomposition:
- Shared package: mode constants, opcode constants, ALU command constants, FSM state enum, and a control-word struct {alu_cmd, mem_read, mem_write, wb_en, branch, status_en}.
- One sub-module, ctrl_decode: purely combinational mode/op_code/s -> control word, instantiated by this block.

Test Plan:
- Reset, then mode 00 op 0100 s=1 -> next cycle out_valid=1, alu_cmd=0010, wb_en=1, status_en=1.
- CMP (op 1010, s=0), then TST (op 1000) -> alu 0100 status 1 wb 0, then alu 0110 status 1 wb 0.
- mode 11, s=1, reg_list=0x0025 -> 3 micro-ops:
  - xfer_reg 0/2/5, addr_offset 0/4/8, mem_read and wb_en set;
  - last_uop only on the third;
  - in_ready=0 during the sequence.
- Same sequence with stall held 2 cycles after the first micro-op -> first micro-op held 3 cycles total, then 2 then 5; offsets unchanged.
- flush during the second micro-op of reg_list=0x000F -> out_valid=0 next cycle, in_ready=1, no further micro-ops; stall+flush together -> flush wins.
- mode 11 with reg_list=0 -> out_valid stays 0, in_ready stays 1. Compiled without BLOCK_XFER_EN: mode 11 gives out_valid=1 with all controls 0.
